// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store initiator for a word-wide data memory.
// Converts byte/half/word RISC-V accesses into word-aligned req/ready
// transactions with byte enables, formats load data, flags misalignment,
// illegal encodings and memory timeouts, and stalls the pipeline meanwhile.
module load_store_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           storeData,
   output logic [31:0]           loadData,
   output logic                  loadDone,
   output logic                  stall,
   output logic                  misaligned,
   output logic                  accessFault,
   output logic                  memReq,
   output logic                  memWe,
   output logic [ADDR_WIDTH-3:0] memAdr,
   output logic [3:0]            memBe,
   output logic [31:0]           memWdata,
   input  logic [31:0]           memRdata,
   input  logic                  memReady
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    funct3_q;
   logic [1:0]    off_q;
   logic          we_q;
   logic [3:0]    be_q;

   logic          req;
   logic          illegal;
   logic          misal;
   logic [3:0]    be_new;
   logic [31:0]   wdata_new;
   logic [31:0]   byte_sh;
   logic [31:0]   half_sh;
   logic [31:0]   fmt_data;

   // Request decode in IDLE: legality, alignment, store lanes and byte enables.
   always_comb begin
      req       = memRead | memWrite;
      illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                  (memWrite && funct3[2]);
      misal     = 1'b0;
      be_new    = 4'b0000;
      wdata_new = storeData;
      case (funct3[1:0])
         2'b00:   misal = 1'b0;
         2'b01:   misal = addr[0];
         default: misal = (addr[1:0] != 2'b00);
      endcase
      // A store wins when both read and write are requested.
      if (memWrite) begin
         case (funct3[1:0])
            2'b00: begin
               be_new    = 4'b0001 << addr[1:0];
               wdata_new = {4{storeData[7:0]}};
            end
            2'b01: begin
               be_new    = 4'b0011 << addr[1:0];
               wdata_new = {2{storeData[15:0]}};
            end
            default: begin
               be_new    = 4'b1111;
               wdata_new = storeData;
            end
         endcase
      end
   end

   // Load formatting: pick the addressed byte/half and extend per funct3.
   always_comb begin
      byte_sh  = memRdata >> {off_q, 3'b000};
      half_sh  = memRdata >> {off_q[1], 4'b0000};
      fmt_data = memRdata;
      case (funct3_q)
         3'b000:  fmt_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
         3'b100:  fmt_data = {24'd0, byte_sh[7:0]};
         3'b001:  fmt_data = {{16{half_sh[15]}}, half_sh[15:0]};
         3'b101:  fmt_data = {16'd0, half_sh[15:0]};
         default: fmt_data = memRdata;
      endcase
   end

   // Bus and stall outputs; derived from state so reset drops them at once.
   always_comb begin
      memReq = (state == S_ACCESS);
      memWe  = memReq & we_q;
      memBe  = memReq ? be_q : 4'b0000;
      stall  = (state == S_ACCESS) || ((state == S_IDLE) && req);
   end

   // Access FSM: IDLE -> ACCESS -> DONE -> IDLE, with one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         we_q        <= 1'b0;
         be_q        <= 4'b0000;
         memAdr      <= '0;
         memWdata    <= 32'd0;
         loadData    <= 32'd0;
         loadDone    <= 1'b0;
         misaligned  <= 1'b0;
         accessFault <= 1'b0;
      end else begin
         loadDone    <= 1'b0;
         misaligned  <= 1'b0;
         accessFault <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (illegal) begin
                     accessFault <= 1'b1;
                  end else if (misal) begin
                     misaligned <= 1'b1;
                  end else begin
                     funct3_q <= funct3;
                     off_q    <= addr[1:0];
                     we_q     <= memWrite;
                     be_q     <= be_new;
                     memAdr   <= addr[ADDR_WIDTH-1:2];
                     memWdata <= wdata_new;
                     cnt      <= '0;
                     state    <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (memReady) begin
                  if (!we_q) loadData <= fmt_data;
                  loadDone <= 1'b1;
                  state    <= S_DONE;
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  // Memory never answered: abandon the access and report a fault.
                  loadData    <= 32'd0;
                  accessFault <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory reference model, scoreboard
// queues for responses and bus transactions, a memory responder and a monitor.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        memRead = 1'b0, memWrite = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'd0, storeData = 32'd0;
   logic [31:0] loadData;
   logic        loadDone, stall, misaligned, accessFault;
   logic        memReq, memWe;
   logic [29:0] memAdr;
   logic [3:0]  memBe;
   logic [31:0] memWdata;
   logic [31:0] memRdata = 32'd0;
   logic        memReady = 1'b0;

   load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
      .funct3(funct3), .addr(addr), .storeData(storeData),
      .loadData(loadData), .loadDone(loadDone), .stall(stall),
      .misaligned(misaligned), .accessFault(accessFault),
      .memReq(memReq), .memWe(memWe), .memAdr(memAdr), .memBe(memBe),
      .memWdata(memWdata), .memRdata(memRdata), .memReady(memReady));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  kind;      // {loadDone, misaligned, accessFault}
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic        we;
      logic [29:0] adr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   exp_t        exp_q[$];
   bus_t        bus_q[$];
   logic [31:0] mem[64];
   logic [7:0]  refb[256];
   int          n_chk = 0, n_fail = 0;
   int          cur_delay = 0;
   bit          cur_noready = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   // Little-endian read from the byte model, extended as the ISA defines.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < acc_size(f3); i++) v = v | (32'(refb[a + i]) << (8 * i));
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
      return v;
   endfunction

   // Memory responder: checks each new transaction, answers after the set delay.
   initial begin
      bit in_req;
      int wcnt;
      bus_t b;
      in_req = 1'b0;
      wcnt = 0;
      forever begin
         @(negedge clk);
         memReady = 1'b0;
         if (!rst_n) begin
            in_req = 1'b0;
         end else if (memReq) begin
            if (!in_req) begin
               in_req = 1'b1;
               wcnt   = cur_delay;
               if (bus_q.size() == 0) begin
                  chk("unexpected_memReq", 32'd1, 32'd0);
               end else begin
                  b = bus_q.pop_front();
                  chk("memWe", 32'(memWe), 32'(b.we));
                  chk("memAdr", 32'(memAdr), 32'(b.adr));
                  chk("memBe", 32'(memBe), 32'(b.be));
                  if (b.we) chk("memWdata", memWdata, b.wdata);
               end
            end
            if (!cur_noready && wcnt == 0) begin
               memReady = 1'b1;
               memRdata = mem[memAdr[5:0]];
               if (memWe)
                  for (int i = 0; i < 4; i++)
                     if (memBe[i]) mem[memAdr[5:0]][8*i +: 8] = memWdata[8*i +: 8];
               in_req = 1'b0;
            end else if (wcnt > 0) begin
               wcnt--;
            end
         end else begin
            in_req = 1'b0;
            if (memWe || memBe != 4'b0000) chk("idle_we_be", {27'd0, memWe, memBe}, 32'd0);
         end
      end
   end

   // Monitor: pops the scoreboard whenever a status pulse appears.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (loadDone || misaligned || accessFault)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {29'd0, loadDone, misaligned, accessFault}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind", {29'd0, loadDone, misaligned, accessFault}, {29'd0, e.kind});
               if (e.chk_data) chk("loadData", loadData, e.data);
            end
         end
      end
   end

   // Issue one request, predict its outcome, and count stall cycles.
   task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input int a, input logic [31:0] sd, input int d, input bit nr);
      exp_t e;
      bus_t b;
      int   sz, stl, exp_stl;
      bit   got;
      sz = acc_size(f3);
      e.chk_data = 1'b0;
      e.data = 32'd0;
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (wr && f3[2])) begin
         e.kind = 3'b001; exp_stl = 1;
      end else if (a % sz != 0) begin
         e.kind = 3'b010; exp_stl = 1;
      end else begin
         b.we = wr;
         b.adr = 30'(a / 4);
         b.be = wr ? 4'(((1 << sz) - 1) << (a % 4)) : 4'b0000;
         b.wdata = 32'd0;
         for (int j = 0; j < 4; j++) b.wdata[8*j +: 8] = sd[8*(j % sz) +: 8];
         bus_q.push_back(b);
         if (nr) begin
            e.kind = 3'b001; e.chk_data = 1'b1; e.data = 32'd0; exp_stl = 17;
         end else begin
            e.kind = 3'b100; exp_stl = d + 2;
            if (!wr) begin
               e.chk_data = 1'b1; e.data = ref_load(f3, a);
            end else begin
               for (int i = 0; i < sz; i++) refb[a + i] = sd[8*i +: 8];
            end
         end
      end
      exp_q.push_back(e);
      @(negedge clk);
      cur_delay = d; cur_noready = nr;
      memRead = rd; memWrite = wr; funct3 = f3; addr = 32'(a); storeData = sd;
      #1 stl = stall ? 1 : 0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         memRead = 1'b0; memWrite = 1'b0;
         #1;
         if (loadDone || misaligned || accessFault) got = 1'b1;
         else if (stall) stl++;
      end
      chk("response_seen", 32'(got), 32'd1);
      chk("stall_cycles", 32'(stl), 32'(exp_stl));
      cur_noready = 1'b0;
   endtask

   initial begin
      bus_t b;
      int   a, sz, r;
      logic [2:0] f3;
      for (int w = 0; w < 64; w++) begin
         mem[w] = $urandom;
         for (int i = 0; i < 4; i++) refb[4*w + i] = mem[w][8*i +: 8];
      end
      repeat (3) @(negedge clk);
      chk("rst_memReq", 32'(memReq), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_pulses", {29'd0, loadDone, misaligned, accessFault}, 32'd0);
      chk("rst_loadData", loadData, 32'd0);
      chk("rst_memAdr_be", {memAdr, memBe[1:0]}, 32'd0);
      rst_n = 1'b1;

      // Directed cases
      do_req(1'b0, 1'b1, 3'b010, 'h10, 32'hDEADBEEF, 0, 1'b0);  // SW
      do_req(1'b0, 1'b1, 3'b000, 'h13, 32'h000000A5, 0, 1'b0);  // SB
      do_req(1'b1, 1'b0, 3'b000, 'h13, 32'h0, 0, 1'b0);         // LB
      do_req(1'b1, 1'b0, 3'b100, 'h13, 32'h0, 1, 1'b0);         // LBU
      do_req(1'b1, 1'b0, 3'b010, 'h10, 32'h0, 0, 1'b0);         // LW readback
      do_req(1'b1, 1'b0, 3'b001, 'h21, 32'h0, 0, 1'b0);         // LH misaligned
      do_req(1'b1, 1'b0, 3'b010, 'h22, 32'h0, 0, 1'b0);         // LW misaligned
      do_req(1'b1, 1'b0, 3'b010, 'h24, 32'h0, 5, 1'b0);         // LW slow memory
      do_req(1'b1, 1'b0, 3'b010, 'h28, 32'h0, 0, 1'b1);         // timeout
      do_req(1'b0, 1'b1, 3'b100, 'h30, 32'h1234, 0, 1'b0);      // store with funct3[2]
      do_req(1'b1, 1'b0, 3'b111, 'h30, 32'h0, 0, 1'b0);         // illegal funct3
      do_req(1'b1, 1'b1, 3'b001, 'h32, 32'hCAFE8001, 0, 1'b0);  // both set: SH
      do_req(1'b1, 1'b0, 3'b101, 'h32, 32'h0, 2, 1'b0);         // LHU
      do_req(1'b1, 1'b0, 3'b001, 'h32, 32'h0, 0, 1'b0);         // LH

      // Reset in the middle of an access aborts it silently
      @(negedge clk);
      b.we = 1'b0; b.adr = 30'h10; b.be = 4'b0000; b.wdata = 32'd0;
      bus_q.push_back(b);
      cur_noready = 1'b1;
      memRead = 1'b1; funct3 = 3'b010; addr = 32'h40;
      @(negedge clk);
      memRead = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_memReq", 32'(memReq), 32'd0);
      chk("abort_stall", 32'(stall), 32'd0);
      repeat (2) @(negedge clk);
      chk("abort_pulses", {29'd0, loadDone, misaligned, accessFault}, 32'd0);
      cur_noready = 1'b0;
      rst_n = 1'b1;
      do_req(1'b1, 1'b0, 3'b010, 'h40, 32'h0, 1, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 80; n++) begin
         f3 = 3'($urandom_range(0, 7));
         r  = $urandom_range(0, 3);
         a  = $urandom_range(0, 255);
         sz = acc_size(f3);
         if (sz > 0 && $urandom_range(0, 2) != 0) a = a - (a % sz);
         do_req(r != 1, r != 0 && r != 2, f3, a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 19) == 0);
      end

      repeat (4) @(negedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
